// File: rtl/cdi_bus_pkg.sv
// Shared types and helpers for the 68070 bus fabric.
//   bus_state_e  : fabric FSM states
//   bus_addr_t   : 24-bit byte address
//   region_match : masked base compare used by the region decoder
package cdi_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2,
    ERR    = 2'd3
  } bus_state_e;

  typedef logic [23:0] bus_addr_t;

  // A region matches when the address and the base agree on every masked bit.
  function automatic logic region_match(input bus_addr_t a,
                                        input bus_addr_t base,
                                        input bus_addr_t mask);
    return ((a & mask) == (base & mask));
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Saturating access watchdog.
//   clk30   in   system clock
//   reset   in   synchronous, active-high
//   clear   in   zero the counter (held while the fabric is idle)
//   enable  in   count one cycle
//   expired out  counter sits at TIMEOUT_CYCLES-1; never asserted when TIMEOUT_CYCLES==0
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk30,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;

  // Watchdog counter: clears on request, otherwise counts up and sticks at its maximum.
  always_ff @(posedge clk30) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Compared against the count before this cycle's increment, so the FSM
  // leaves ACCESS on the edge where the count would pass TIMEOUT_CYCLES-1.
  assign expired = (TIMEOUT_CYCLES > 0) && (cnt_r == LIMIT);

endmodule

// File: rtl/attex_bus_fabric.sv
// 68070 bus fabric: address decode, one-hot chip selects, ack/wait-state
// generation, bus error on unmapped access or watchdog timeout, and an
// interrupt-acknowledge path that bypasses decoding.
//   clk30, reset        clock, synchronous active-high reset
//   as, uds, lds        CPU address and byte strobes
//   write_strobe        1 = write cycle (ack/err timing identical to reads)
//   addr[22:0]          CPU addr[23:1]
//   iack_sel            one-hot region answering an interrupt acknowledge
//   dev_dout, dev_ack   per-region read data and ready
//   dev_cs              one-hot chip select (registered)
//   data_in             read data to CPU (registered, held between accesses)
//   bus_ack, bus_err    transfer acknowledge / bus error (registered)
module attex_bus_fabric
  import cdi_bus_pkg::*;
#(
  parameter int NREGIONS = 4,
  parameter logic [NREGIONS*24-1:0] REGION_BASE = {24'hE00000, 24'hD00000, 24'h800000, 24'h000000},
  parameter logic [NREGIONS*24-1:0] REGION_MASK = {24'hF00000, 24'hF00000, 24'hC00000, 24'hC00000},
  parameter logic [NREGIONS*8-1:0]  REGION_WAIT = {8'd0, 8'd0, 8'd0, 8'd0},
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                   clk30,
  input  logic                   reset,
  input  logic                   as,
  input  logic                   uds,
  input  logic                   lds,
  input  logic                   write_strobe,
  input  logic [22:0]            addr,
  input  logic [NREGIONS-1:0]    iack_sel,
  input  logic [NREGIONS*16-1:0] dev_dout,
  input  logic [NREGIONS-1:0]    dev_ack,
  output logic [NREGIONS-1:0]    dev_cs,
  output logic [15:0]            data_in,
  output logic                   bus_ack,
  output logic                   bus_err
);

  localparam int IDX_W = (NREGIONS > 1) ? $clog2(NREGIONS) : 1;

  bus_state_e         state_r;
  logic [IDX_W-1:0]   sel_r;
  logic [7:0]         wait_cnt_r;

  bus_addr_t          byte_addr_s;
  logic               match_s;
  logic               hit_s;
  logic [IDX_W-1:0]   hit_idx_s;
  logic [NREGIONS-1:0] hit_oh_s;
  logic               iack_found_s;
  logic [15:0]        iack_dout_s;
  logic [15:0]        cur_dout_s;
  logic               cur_ack_s;
  logic [7:0]         cur_wait_s;
  logic               wait_done_s;
  logic               start_s;
  logic               wd_expired_s;
  logic               unused_s;

  // Writes share the read timing exactly, so the direction bit is not needed.
  assign unused_s = write_strobe;

  assign byte_addr_s = {addr, 1'b0};
  assign start_s     = as && (uds || lds);

  // Region decoder: scan upward and keep the first (lowest-index) hit.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = '0;
    match_s   = 1'b0;
    for (int i = 0; i < NREGIONS; i++) begin
      match_s   = region_match(byte_addr_s, REGION_BASE[i*24 +: 24], REGION_MASK[i*24 +: 24]);
      hit_idx_s = (match_s && !hit_s) ? IDX_W'(i) : hit_idx_s;
      hit_s     = hit_s | match_s;
    end
  end

  // One-hot chip select for the decoded region.
  always_comb begin
    hit_oh_s = '0;
    for (int i = 0; i < NREGIONS; i++) begin
      hit_oh_s[i] = (hit_idx_s == IDX_W'(i));
    end
  end

  // Interrupt-acknowledge data: lowest set iack_sel bit supplies the vector.
  always_comb begin
    iack_found_s = 1'b0;
    iack_dout_s  = 16'h0000;
    for (int i = 0; i < NREGIONS; i++) begin
      iack_dout_s  = (iack_sel[i] && !iack_found_s) ? dev_dout[i*16 +: 16] : iack_dout_s;
      iack_found_s = iack_found_s | iack_sel[i];
    end
  end

  // Per-region mux for the selected device's data, ready and wait count.
  always_comb begin
    cur_dout_s = 16'h0000;
    cur_ack_s  = 1'b0;
    cur_wait_s = 8'd0;
    for (int i = 0; i < NREGIONS; i++) begin
      cur_dout_s = (sel_r == IDX_W'(i)) ? dev_dout[i*16 +: 16]   : cur_dout_s;
      cur_ack_s  = (sel_r == IDX_W'(i)) ? dev_ack[i]             : cur_ack_s;
      cur_wait_s = (sel_r == IDX_W'(i)) ? REGION_WAIT[i*8 +: 8]  : cur_wait_s;
    end
  end

  // A zero wait count hands completion to the device; otherwise count N cycles
  // from chip-select rise (counter value N-1 before this edge's increment).
  assign wait_done_s = (cur_wait_s == 8'd0) ? cur_ack_s : (wait_cnt_r == (cur_wait_s - 8'd1));

  bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk30   (clk30),
    .reset   (reset),
    .clear   (state_r == IDLE),
    .enable  (state_r == ACCESS),
    .expired (wd_expired_s)
  );

  // Bus FSM with registered chip selects, read data, ack and error.
  always_ff @(posedge clk30) begin
    if (reset) begin
      state_r    <= IDLE;
      sel_r      <= '0;
      wait_cnt_r <= 8'd0;
      dev_cs     <= '0;
      data_in    <= 16'h0000;
      bus_ack    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wait_cnt_r <= 8'd0;
          if (start_s) begin
            if (|iack_sel) begin
              // Interrupt acknowledge overrides decoding; no chip select.
              state_r <= ACK;
              data_in <= iack_dout_s;
              bus_ack <= 1'b1;
              dev_cs  <= '0;
            end else if (!hit_s) begin
              state_r <= ERR;
              bus_err <= 1'b1;
            end else begin
              state_r <= ACCESS;
              sel_r   <= hit_idx_s;
              dev_cs  <= hit_oh_s;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt_r != 8'hFF) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
          if (!as) begin
            // CPU abandoned the cycle: release quietly.
            state_r <= IDLE;
            dev_cs  <= '0;
          end else if (wait_done_s) begin
            // Ack takes priority over a watchdog expiry in the same cycle.
            state_r <= ACK;
            data_in <= cur_dout_s;
            bus_ack <= 1'b1;
          end else if (wd_expired_s) begin
            state_r <= ERR;
            bus_err <= 1'b1;
          end
        end
        ACK: begin
          if (!as) begin
            state_r <= IDLE;
            bus_ack <= 1'b0;
            dev_cs  <= '0;
          end
        end
        ERR: begin
          if (!as) begin
            state_r <= IDLE;
            bus_err <= 1'b0;
            dev_cs  <= '0;
          end
        end
        default: begin
          state_r <= IDLE;
          dev_cs  <= '0;
          bus_ack <= 1'b0;
          bus_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_attex_bus_fabric.sv
// Scoreboard bench for attex_bus_fabric: stimulus pushes the expected
// response (ack/err, data, chip select, edge number) into a queue; a monitor
// pops and compares each time bus_ack or bus_err rises.
module tb_attex_bus_fabric;

  logic        clk30 = 1'b0;
  logic        reset;
  logic        as, uds, lds, write_strobe;
  logic [22:0] addr;
  logic [3:0]  iack_sel, dev_ack, dev_cs;
  logic [63:0] dev_dout;
  logic [15:0] data_in;
  logic        bus_ack, bus_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0;

  typedef struct {
    bit          is_err;
    logic [15:0] data;
    logic [3:0]  cs;
    int          at;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  logic prev_ack = 1'b0;
  logic prev_err = 1'b0;

  attex_bus_fabric #(
    .REGION_WAIT    ({8'd0, 8'd4, 8'd0, 8'd0}),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk30        (clk30),
    .reset        (reset),
    .as           (as),
    .uds          (uds),
    .lds          (lds),
    .write_strobe (write_strobe),
    .addr         (addr),
    .iack_sel     (iack_sel),
    .dev_dout     (dev_dout),
    .dev_ack      (dev_ack),
    .dev_cs       (dev_cs),
    .data_in      (data_in),
    .bus_ack      (bus_ack),
    .bus_err      (bus_err)
  );

  always #5 clk30 = ~clk30;

  always @(posedge clk30) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input bit is_err, input logic [15:0] d, input logic [3:0] cs,
                      input int at, input string nm);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    e.cs     = cs;
    e.at     = at;
    e.name   = nm;
    exp_q.push_back(e);
  endtask

  // Advance n rising edges, then step 1 time unit off the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk30);
    #1;
  endtask

  task automatic start(input logic [23:0] byte_addr);
    addr = byte_addr[23:1];
    as   = 1'b1;
    uds  = 1'b1;
    lds  = 1'b1;
    t0   = cyc;
  endtask

  // Monitor: every new ack/err must match the head of the expectation queue.
  always @(negedge clk30) begin
    exp_t e;
    if (!reset && ((bus_ack && !prev_ack) || (bus_err && !prev_err))) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", {30'd0, bus_err, bus_ack}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_kind"}, {30'd0, bus_err, bus_ack}, e.is_err ? 32'd2 : 32'd1);
        check({e.name, "_edge"}, cyc, e.at);
        check({e.name, "_cs"}, {28'd0, dev_cs}, {28'd0, e.cs});
        if (!e.is_err) check({e.name, "_data"}, {16'd0, data_in}, {16'd0, e.data});
      end
    end
    prev_ack <= bus_ack;
    prev_err <= bus_err;
  end

  initial begin
    reset        = 1'b1;
    as           = 1'b0;
    uds          = 1'b0;
    lds          = 1'b0;
    write_strobe = 1'b0;
    addr         = 23'd0;
    iack_sel     = 4'b0000;
    dev_ack      = 4'b0000;
    dev_dout     = {16'hD333, 16'hC222, 16'hB111, 16'hA000};

    // Reset state
    tick(3);
    check("rst_cs",   {28'd0, dev_cs}, 32'd0);
    check("rst_data", {16'd0, data_in}, 32'd0);
    check("rst_ack",  {31'd0, bus_ack}, 32'd0);
    check("rst_err",  {31'd0, bus_err}, 32'd0);
    reset = 1'b0;
    tick(2);

    // 1: region0 read, dev_ack raised on the third cycle after as
    start(24'h000100);
    push(1'b0, 16'hA000, 4'b0001, t0 + 4, "t1_read_r0");
    tick(1);
    check("t1_cs_rise", {28'd0, dev_cs}, 32'h1);
    tick(2);
    dev_ack = 4'b0001;
    tick(2);
    dev_ack = 4'b0000;
    as = 1'b0;
    tick(1);
    check("t1_cs_drop", {28'd0, dev_cs}, 32'd0);
    check("t1_ack_drop", {31'd0, bus_ack}, 32'd0);
    check("t1_data_hold", {16'd0, data_in}, 32'hA000);
    tick(1);

    // 2: region2 has a fixed four-cycle wait, dev_ack held low
    start(24'hD00040);
    push(1'b0, 16'hC222, 4'b0100, t0 + 5, "t2_wait4");
    tick(1);
    check("t2_cs_rise", {28'd0, dev_cs}, 32'h4);
    tick(3);
    check("t2_no_early_ack", {31'd0, bus_ack}, 32'd0);
    tick(2);
    as = 1'b0;
    tick(1);
    check("t2_cs_drop", {28'd0, dev_cs}, 32'd0);
    tick(1);

    // Write to region1 with dev_ack already high: minimum latency, data still latched
    dev_ack = 4'b0010;
    write_strobe = 1'b1;
    start(24'h800010);
    push(1'b0, 16'hB111, 4'b0010, t0 + 2, "tw_write_r1");
    tick(3);
    as = 1'b0;
    write_strobe = 1'b0;
    dev_ack = 4'b0000;
    tick(2);

    // 3: unmapped address
    start(24'h600000);
    push(1'b1, 16'h0000, 4'b0000, t0 + 1, "t3_unmapped");
    tick(1);
    check("t3_cs_zero", {28'd0, dev_cs}, 32'd0);
    tick(2);
    as = 1'b0;
    @(negedge clk30);
    check("t3_err_held", {31'd0, bus_err}, 32'd1);
    tick(1);
    check("t3_err_clear", {31'd0, bus_err}, 32'd0);
    tick(1);

    // 4: watchdog timeout on region0
    start(24'h000200);
    push(1'b1, 16'h0000, 4'b0001, t0 + 17, "t4_timeout");
    tick(16);
    check("t4_no_early_err", {31'd0, bus_err}, 32'd0);
    tick(1);
    check("t4_cs_held", {28'd0, dev_cs}, 32'h1);
    as = 1'b0;
    tick(1);
    check("t4_cs_drop", {28'd0, dev_cs}, 32'd0);
    check("t4_err_clear", {31'd0, bus_err}, 32'd0);
    tick(1);

    // 5: interrupt acknowledge overrides a region0 address match
    iack_sel = 4'b0010;
    start(24'h000100);
    uds = 1'b0;
    push(1'b0, 16'hB111, 4'b0000, t0 + 1, "t5_iack");
    tick(1);
    check("t5_cs_zero", {28'd0, dev_cs}, 32'd0);
    tick(1);
    as = 1'b0;
    iack_sel = 4'b0000;
    tick(1);
    check("t5_ack_drop", {31'd0, bus_ack}, 32'd0);
    tick(1);

    // 6a: reset in the middle of an ACCESS
    start(24'h000300);
    tick(4);
    check("t6_cs_mid", {28'd0, dev_cs}, 32'h1);
    reset = 1'b1;
    as = 1'b0;
    tick(1);
    check("t6_rst_cs",   {28'd0, dev_cs}, 32'd0);
    check("t6_rst_data", {16'd0, data_in}, 32'd0);
    check("t6_rst_ack",  {31'd0, bus_ack}, 32'd0);
    check("t6_rst_err",  {31'd0, bus_err}, 32'd0);
    reset = 1'b0;
    tick(2);

    // 6b: as drops part-way through region2's wait: silent release
    start(24'hD00000);
    tick(2);
    as = 1'b0;
    tick(1);
    check("t6_abort_cs", {28'd0, dev_cs}, 32'd0);
    tick(20);
    check("t6_abort_ack", {31'd0, bus_ack}, 32'd0);
    check("t6_abort_err", {31'd0, bus_err}, 32'd0);

    check("responses_outstanding", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
